// File: rtl/live_out_sequencer.sv
// Walks location-memory entries, reads the selected PE register file and streams each word out.
// Define LIVE_OUT_SEQ_ONEHOT_CHECK_EN to flag and skip entries whose PE selection is not one-hot.
module live_out_sequencer #(
    parameter int unsigned ADDR_WIDTH    = 9,
    parameter int unsigned RF_ADDR_WIDTH = 9,
    parameter int unsigned NR_OF_PES     = 16,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [ADDR_WIDTH-1:0]           base_addr_i,
    input  logic [ADDR_WIDTH-1:0]           count_i,
    output logic [ADDR_WIDTH-1:0]           lim_addr_o,
    input  logic [NR_OF_PES-1:0]            lim_pe_selection_i,
    input  logic [RF_ADDR_WIDTH-1:0]        lim_rf_addr_i,
    output logic [NR_OF_PES-1:0]            pe_read_en_o,
    output logic [RF_ADDR_WIDTH-1:0]        rf_addr_o,
    input  logic [NR_OF_PES*DATA_WIDTH-1:0] pe_data_i,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            data_valid_o,
    input  logic                            data_ready_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLookup,
        StCapture,
        StOutput,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]    remain_q, remain_d;
    logic [NR_OF_PES-1:0]     sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]    lim_addr_q, lim_addr_d;
    logic [RF_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic                     last_entry;

`ifdef LIVE_OUT_SEQ_ONEHOT_CHECK_EN
    logic error_q, error_d;
    logic sel_onehot;

    assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - NR_OF_PES'(1))) == '0);
`endif

    assign last_entry = (remain_q == ADDR_WIDTH'(1));

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(NR_OF_PES); k++) begin
            if (sel_q[k]) begin
                sel_data = sel_data | pe_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            remain_q   <= '0;
            sel_q      <= '0;
            lim_addr_q <= '0;
            rf_addr_q  <= '0;
            data_q     <= '0;
`ifdef LIVE_OUT_SEQ_ONEHOT_CHECK_EN
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            sel_q      <= sel_d;
            lim_addr_q <= lim_addr_d;
            rf_addr_q  <= rf_addr_d;
            data_q     <= data_d;
`ifdef LIVE_OUT_SEQ_ONEHOT_CHECK_EN
            error_q    <= error_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        sel_d      = sel_q;
        lim_addr_d = lim_addr_q;
        rf_addr_d  = rf_addr_q;
        data_d     = data_q;
`ifdef LIVE_OUT_SEQ_ONEHOT_CHECK_EN
        error_d    = error_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    addr_d   = base_addr_i;
                    remain_d = count_i;
                    state_d  = (count_i == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                lim_addr_d = addr_q;
                state_d    = StLookup;
            end
            StLookup: begin
                sel_d     = lim_pe_selection_i;
                rf_addr_d = lim_rf_addr_i;
                state_d   = StCapture;
            end
            StCapture: begin
`ifdef LIVE_OUT_SEQ_ONEHOT_CHECK_EN
                if (!sel_onehot) begin
                    // Bad entry: consume it without presenting a word.
                    error_d  = 1'b1;
                    remain_d = remain_q - ADDR_WIDTH'(1);
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    state_d  = last_entry ? StDone : StFetch;
                end else begin
                    data_d  = sel_data;
                    state_d = StOutput;
                end
`else
                data_d  = sel_data;
                state_d = StOutput;
`endif
            end
            StOutput: begin
                if (data_ready_i) begin
                    remain_d = remain_q - ADDR_WIDTH'(1);
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    state_d  = last_entry ? StDone : StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Address and RF address track the live value in their issue state and hold it otherwise.
    assign lim_addr_o   = (state_q == StFetch) ? addr_q : lim_addr_q;
    assign rf_addr_o    = (state_q == StLookup) ? lim_rf_addr_i : rf_addr_q;
    assign pe_read_en_o = (state_q == StLookup) ? lim_pe_selection_i : '0;
    assign data_o       = data_q;
    assign data_valid_o = (state_q == StOutput);
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);
`ifdef LIVE_OUT_SEQ_ONEHOT_CHECK_EN
    assign error_o      = error_q;
`else
    assign error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_live_out_sequencer.sv
// Self-checking bench for live_out_sequencer: directed scenarios plus randomized runs
// compared against a transaction-level model of the entry walk.
module tb_live_out_sequencer;

    localparam int AW = 9;
    localparam int RW = 9;
    localparam int NP = 16;
    localparam int DW = 32;

`ifdef LIVE_OUT_SEQ_ONEHOT_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW-1:0]    count_in;
    logic [AW-1:0]    lim_addr;
    logic [NP-1:0]    lim_sel;
    logic [RW-1:0]    lim_rf;
    logic [NP-1:0]    pe_read_en;
    logic [RW-1:0]    rf_addr;
    logic [NP*DW-1:0] pe_data;
    logic [DW-1:0]    data;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             done;
    logic             error;

    int checks = 0;
    int errors = 0;

    logic [NP-1:0] mem_sel [0:511];
    logic [RW-1:0] mem_rf  [0:511];
    logic [DW-1:0] pe_word [NP];
    bit            plain;
    logic [31:0]   salt;
    logic          exp_err;

    always #5 clk = ~clk;

    live_out_sequencer dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .start_i            (start),
        .base_addr_i        (base_addr),
        .count_i            (count_in),
        .lim_addr_o         (lim_addr),
        .lim_pe_selection_i (lim_sel),
        .lim_rf_addr_i      (lim_rf),
        .pe_read_en_o       (pe_read_en),
        .rf_addr_o          (rf_addr),
        .pe_data_i          (pe_data),
        .data_o             (data),
        .data_valid_o       (data_valid),
        .data_ready_i       (data_ready),
        .busy_o             (busy),
        .done_o             (done),
        .error_o            (error)
    );

    function automatic logic [DW-1:0] pe_val(int k, logic [RW-1:0] rf);
        if (plain) return 32'hA0 + 32'(rf);
        return (32'(k) << 24) ^ (32'(rf) * 32'h9E37_79B1) ^ salt;
    endfunction

    // Location memory and PE register files, each with one cycle of read latency.
    always @(posedge clk) begin
        lim_sel <= mem_sel[lim_addr];
        lim_rf  <= mem_rf[lim_addr];
        for (int k = 0; k < NP; k++) begin
            if (pe_read_en[k]) pe_word[k] <= pe_val(k, rf_addr);
        end
    end

    always_comb begin
        pe_data = '0;
        for (int k = 0; k < NP; k++) pe_data[k*DW +: DW] = pe_word[k];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_seq(input logic [AW-1:0] base, input logic [AW-1:0] count, input int mode);
        logic [DW-1:0] exp_words [$];
        logic [NP-1:0] exp_sels  [$];
        logic [RW-1:0] exp_rfs   [$];
        int            cycles = 0;
        int            stalls = 0;
        int            hold = 0;
        int            widx = 0;
        bit            finished = 1'b0;
        logic [AW-1:0] addr0;
        // Model: each entry is fetched, looked up and (unless rejected) emitted as one word.
        for (int i = 0; i < int'(count); i++) begin
            logic [AW-1:0] a;
            logic [NP-1:0] s;
            logic [DW-1:0] w;
            a = AW'((int'(base) + i) % 512);
            s = mem_sel[a];
            exp_sels.push_back(s);
            exp_rfs.push_back(mem_rf[a]);
            if (CheckEn && $countones(s) != 1) begin
                exp_err = 1'b1;
                cycles += 3;
            end else begin
                w = '0;
                for (int k = 0; k < NP; k++) if (s[k]) w |= pe_val(k, mem_rf[a]);
                exp_words.push_back(w);
                cycles += 4;
            end
        end
        addr0 = lim_addr;
        @(negedge clk);
        start = 1'b1; base_addr = base; count_in = count; data_ready = 1'b1;
        for (int i = 1; i <= 30 * int'(count) + 20 && !finished; i++) begin
            @(negedge clk);
            start = 1'b0;
            case (mode)
                1: data_ready = ($urandom_range(0, 3) != 0);
                2: data_ready = !(widx == 1 && hold < 5);
                default: data_ready = 1'b1;
            endcase
            if (i == 1) begin
                chk("lim_addr_first", lim_addr, (count == 0) ? addr0 : base);
                chk("busy_running", busy, 1);
            end
            if (pe_read_en != '0) begin
                if (exp_sels.size() == 0) chk("extra_lookup", pe_read_en, 0);
                else begin
                    chk("pe_read_en", pe_read_en, exp_sels.pop_front());
                    chk("rf_addr", rf_addr, exp_rfs.pop_front());
                end
            end
            if (data_valid) begin
                if (exp_words.size() == 0) chk("extra_word", data, 0);
                else begin
                    chk("data", data, exp_words[0]);
                    if (data_ready) begin
                        void'(exp_words.pop_front());
                        widx++;
                    end else begin
                        stalls++;
                        hold++;
                    end
                end
            end
            if (done) begin
                chk("done_cycle", i, 1 + cycles + stalls);
                chk("words_left", exp_words.size(), 0);
                chk("lookups_left", exp_sels.size(), 0);
                if (mode == 2) chk("stall_count", stalls, 5);
                @(negedge clk);
                chk("done_pulse", done, 0);
                chk("busy_after", busy, 0);
                finished = 1'b1;
            end
        end
        if (!finished) chk("timeout", 0, 1);
        data_ready = 1'b1;
        chk("error_o", error, exp_err);
    endtask

    task automatic fill_random(input logic [AW-1:0] base, input int count);
        for (int i = 0; i < count; i++) begin
            int a, b;
            logic [AW-1:0] ad;
            ad = AW'((int'(base) + i) % 512);
            a = $urandom_range(0, NP - 1);
            b = (a + 1 + $urandom_range(0, NP - 2)) % NP;
            mem_sel[ad] = NP'(1) << a;
            if ($urandom_range(0, 4) == 0) mem_sel[ad] = mem_sel[ad] | (NP'(1) << b);
            mem_rf[ad] = RW'($urandom);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; base_addr = '0; count_in = '0; data_ready = 1'b1;
        plain = 1'b1; salt = '0; exp_err = 1'b0;
        for (int i = 0; i < 512; i++) begin
            mem_sel[i] = NP'(1) << (i % NP);
            mem_rf[i]  = RW'(i);
        end
        repeat (2) @(negedge clk);
        chk("rst_lim_addr", lim_addr, 0);
        chk("rst_pe_read_en", pe_read_en, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_data", data, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;

        // Three entries selecting PEs 2/7/15, words 0xAA/0xAB/0xAC.
        mem_sel[5] = 16'h0004; mem_rf[5] = 9'd10;
        mem_sel[6] = 16'h0080; mem_rf[6] = 9'd11;
        mem_sel[7] = 16'h8000; mem_rf[7] = 9'd12;
        run_seq(9'd5, 9'd3, 0);
        run_seq(9'd5, 9'd3, 2);
        run_seq(9'd77, 9'd0, 0);

        mem_sel[511] = 16'h0010; mem_rf[511] = 9'd300;
        mem_sel[0]   = 16'h0200; mem_rf[0]   = 9'd45;
        run_seq(9'd511, 9'd2, 0);

        // Reset while the first of three words is waiting in OUTPUT.
        @(negedge clk);
        start = 1'b1; base_addr = 9'd100; count_in = 9'd3; data_ready = 1'b0;
        n = 0;
        @(negedge clk);
        start = 1'b0;
        while (!data_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_output", data_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", data_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_lim_addr", lim_addr, 0);
        chk("abort_data", data, 0);
        rst = 1'b0; data_ready = 1'b1; exp_err = 1'b0;
        run_seq(9'd5, 9'd3, 0);

        // Two-PE selection in the middle entry.
        mem_sel[20] = 16'h0004; mem_rf[20] = 9'd1;
        mem_sel[21] = 16'h0006; mem_rf[21] = 9'd2;
        mem_sel[22] = 16'h0100; mem_rf[22] = 9'd3;
        run_seq(9'd20, 9'd3, 0);
        run_seq(9'd5, 9'd1, 0);

        plain = 1'b0;
        for (int r = 0; r < 8; r++) begin
            logic [AW-1:0] b;
            int c;
            salt = $urandom;
            b = AW'($urandom);
            c = $urandom_range(1, 6);
            fill_random(b, c);
            run_seq(b, AW'(c), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
